// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. Owns the PC, requests words from instruction
// memory over a req/ack handshake, buffers returned words in a small fetch
// queue and drives the IF/ID register consumed by the decode-stage control
// unit. A taken branch/jump (redirect) flushes everything and refetches from
// the target; a Halt word (opcode 4'b1111) reaching IF/ID stops fetching.
//
// Configuration macro: IFU_PREFETCH_EN
//   defined   - two-entry queue; fetching continues during stall until two
//               words are buffered.
//   undefined - one-entry queue; a new request is raised only when the queue
//               is empty and nothing is outstanding.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   imem_req     fetch request, held with imem_addr until imem_ack
//   imem_addr    byte address of the requested word
//   imem_ack     imem_rdata valid, completes the open request
//   imem_rdata   returned instruction word
//   stall        decode stage holds IF/ID
//   redirect     taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc  redirect target (bit 0 treated as 0)
//   instr        IF/ID instruction word
//   opCode       instr[15:12]
//   funCode      instr[3:0]
//   pc_out       address of instr
//   id_valid     IF/ID holds a live instruction
//   halted       Halt reached IF/ID, fetch stopped
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic [3:0]  opCode,
    output logic [3:0]  funCode,
    output logic [15:0] pc_out,
    output logic        id_valid,
    output logic        halted
);

`ifdef IFU_PREFETCH_EN
    localparam logic [1:0] QDEPTH = 2'd2;
`else
    localparam logic [1:0] QDEPTH = 2'd1;
`endif
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;             // address of the open/next request
    logic [15:0] drain_pc_r, drain_pc_s; // refetch target while draining
    logic        req_r, req_s;
    logic [15:0] instr_r, instr_s;
    logic [15:0] pc_out_r, pc_out_s;
    logic        valid_r, valid_s;
    logic        halted_r, halted_s;
    logic [1:0]  qcnt_r, qcnt_s;
    logic [15:0] q0_instr_r, q0_instr_s, q0_pc_r, q0_pc_s;
    logic [15:0] q1_instr_r, q1_instr_s, q1_pc_r, q1_pc_s;

    logic        ack_s;        // open request completes this cycle
    logic        open_s;       // open request stays unacked past this edge
    logic        free_s;       // IF/ID may take a new word this edge
    logic        head_ok_s;    // queue holds at least one word
    logic        ifid_load_s;  // a word is available for a free IF/ID
    logic [15:0] load_instr_s;
    logic [15:0] load_pc_s;
    logic [15:0] target_s;
    logic        deq_s;
    logic        enq_s;
    logic        wpos_s;       // tail slot for an enqueue

    assign ack_s        = req_r & imem_ack;
    assign open_s       = req_r & ~imem_ack;
    assign free_s       = ~valid_r | ~stall;
    assign head_ok_s    = (qcnt_r != 2'd0);
    assign ifid_load_s  = free_s & (head_ok_s | ack_s);
    // Queue head has priority over the returning word so order is preserved;
    // the memory word goes straight to IF/ID only when the queue is empty.
    assign load_instr_s = head_ok_s ? q0_instr_r : imem_rdata;
    assign load_pc_s    = head_ok_s ? q0_pc_r    : pc_r;
    assign target_s     = redirect_pc & 16'hFFFE;
    // Tail index after a possible dequeue; a full queue never enqueues
    // without dequeuing, so the low count bit is sufficient.
    assign wpos_s       = qcnt_r[0] ^ deq_s;

    // Next-state, PC, request and IF/ID logic
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        drain_pc_s = drain_pc_r;
        req_s      = req_r;
        instr_s    = instr_r;
        pc_out_s   = pc_out_r;
        valid_s    = valid_r;
        halted_s   = halted_r;
        qcnt_s     = qcnt_r;
        deq_s      = 1'b0;
        enq_s      = 1'b0;
        if (redirect) begin
            // Redirect beats stall, halt and any same-cycle ack.
            valid_s  = 1'b0;
            qcnt_s   = 2'd0;
            halted_s = 1'b0;
            req_s    = 1'b1;
            if (open_s) begin
                // Keep the open request on the bus and throw its data away.
                state_s    = ST_DRAIN;
                drain_pc_s = target_s;
            end else begin
                state_s = ST_FETCH;
                pc_s    = target_s;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (ifid_load_s) begin
                        instr_s  = load_instr_s;
                        pc_out_s = load_pc_s;
                        valid_s  = 1'b1;
                    end else if (free_s) begin
                        valid_s = 1'b0;
                    end else begin
                        valid_s = valid_r;
                    end
                    deq_s  = ifid_load_s & head_ok_s;
                    enq_s  = ack_s & ~(ifid_load_s & ~head_ok_s);
                    pc_s   = ack_s ? (pc_r + 16'd2) : pc_r;
                    qcnt_s = qcnt_r - {1'b0, deq_s} + {1'b0, enq_s};
                    if (ifid_load_s && (load_instr_s[15:12] == OP_HALT)) begin
                        state_s  = ST_HALT;
                        halted_s = 1'b1;
                        qcnt_s   = 2'd0;
                        req_s    = open_s;
                    end else begin
                        // New requests only when the queue can absorb the
                        // reply, so acks are never dropped under stall.
                        req_s = open_s | (qcnt_s < QDEPTH);
                    end
                end
                ST_DRAIN: begin
                    req_s = 1'b1;
                    if (ack_s) begin
                        state_s = ST_FETCH;
                        pc_s    = drain_pc_r;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                ST_HALT: begin
                    halted_s = 1'b1;
                    req_s    = open_s;
                end
                default: begin
                    state_s  = ST_FETCH;
                    req_s    = 1'b0;
                    valid_s  = 1'b0;
                    qcnt_s   = 2'd0;
                    halted_s = 1'b0;
                end
            endcase
        end
    end

    // Fetch queue storage: head shifts down on dequeue, tail written on enqueue
    always_comb begin
        q0_instr_s = q0_instr_r;
        q0_pc_s    = q0_pc_r;
        q1_instr_s = q1_instr_r;
        q1_pc_s    = q1_pc_r;
        if (enq_s && !wpos_s) begin
            q0_instr_s = imem_rdata;
            q0_pc_s    = pc_r;
        end else if (deq_s) begin
            q0_instr_s = q1_instr_r;
            q0_pc_s    = q1_pc_r;
        end else begin
            q0_instr_s = q0_instr_r;
            q0_pc_s    = q0_pc_r;
        end
        if (enq_s && wpos_s) begin
            q1_instr_s = imem_rdata;
            q1_pc_s    = pc_r;
        end else begin
            q1_instr_s = q1_instr_r;
            q1_pc_s    = q1_pc_r;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            drain_pc_r <= RESET_PC;
            req_r      <= 1'b0;
            instr_r    <= 16'h0000;
            pc_out_r   <= 16'h0000;
            valid_r    <= 1'b0;
            halted_r   <= 1'b0;
            qcnt_r     <= 2'd0;
            q0_instr_r <= 16'h0000;
            q0_pc_r    <= 16'h0000;
            q1_instr_r <= 16'h0000;
            q1_pc_r    <= 16'h0000;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            drain_pc_r <= drain_pc_s;
            req_r      <= req_s;
            instr_r    <= instr_s;
            pc_out_r   <= pc_out_s;
            valid_r    <= valid_s;
            halted_r   <= halted_s;
            qcnt_r     <= qcnt_s;
            q0_instr_r <= q0_instr_s;
            q0_pc_r    <= q0_pc_s;
            q1_instr_r <= q1_instr_s;
            q1_pc_r    <= q1_pc_s;
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = pc_r;
    assign instr     = instr_r;
    assign opCode    = instr_r[15:12];
    assign funCode   = instr_r[3:0];
    assign pc_out    = pc_out_r;
    assign id_valid  = valid_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A memory responder answers
// requests with programmable latency; a stream model tracks which address
// decode must see next (sequential +2, restarted by redirect) and checks
// every instruction decode consumes, IF/ID hold under stall, flush on
// redirect and handshake stability. Directed scenarios cover reset, bypass
// timing, stall buffering, drain, redirect/ack collision, halt, PC wrap and
// mid-request reset; a randomized run closes with a progress check.
// Honors IFU_PREFETCH_EN for the expected queue depth.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

`ifdef IFU_PREFETCH_EN
    localparam int QD = 2;
`else
    localparam int QD = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ack, stall, redirect, id_valid, halted;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, instr, pc_out;
    logic [3:0]  opCode, funCode;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // memory / model state
    int          mem_wait, lat_fix, ack_cnt, consumed, c0;
    bit          lat_rand, model_on, halt_en, found;
    logic [15:0] exp_pc;
    logic        p_rst, p_stall, p_redirect, p_valid, p_req, p_ack;
    logic [15:0] p_rpc, p_instr, p_pcout, p_addr;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr      (instr),
        .opCode     (opCode),
        .funCode    (funCode),
        .pc_out     (pc_out),
        .id_valid   (id_valid),
        .halted     (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory image: scrambled words with no accidental Halt opcode, fixed
    // words at 0 and 2, and an optional Halt at address 6.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        w = (a * 16'h9E37) ^ 16'h5A5A ^ (a >> 3);
        if (w[15:12] == 4'hF) w[15] = 1'b0;
        if (a == 16'h0000) w = 16'h0123;
        else if (a == 16'h0002) w = 16'h1456;
        else if (a == 16'h0006 && halt_en) w = 16'hF000;
        return w;
    endfunction

    // One clock: answer the memory, advance, then check the new outputs.
    task automatic cyc();
        if (imem_req === 1'b1 && mem_wait == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            if (imem_req === 1'b1 && mem_wait > 0) mem_wait--;
        end
        if (imem_ack) ack_cnt++;
        p_rst = rst; p_stall = stall; p_redirect = redirect; p_rpc = redirect_pc;
        p_valid = id_valid; p_instr = instr; p_pcout = pc_out;
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
        @(posedge clk);
        #1;
        if (p_ack) mem_wait = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
        if (p_rst !== 1'b1) begin
            if (p_req === 1'b1 && !p_ack) begin
                check_eq("req_hold", imem_req, 1);
                check_eq("addr_hold", imem_addr, p_addr);
            end
            if (model_on) begin
                if (p_redirect) begin
                    check_eq("flush_valid", id_valid, 0);
                    exp_pc = p_rpc & 16'hFFFE;
                end else if (p_valid === 1'b1 && p_stall) begin
                    check_eq("hold_valid", id_valid, 1);
                    check_eq("hold_instr", instr, p_instr);
                    check_eq("hold_pc", pc_out, p_pcout);
                end else if (p_valid === 1'b1) begin
                    check_eq("seq_pc", p_pcout, exp_pc);
                    check_eq("seq_instr", p_instr, mem_word(exp_pc));
                    exp_pc = exp_pc + 16'd2;
                    consumed++;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        cyc();
        rst = 1'b0;
        mem_wait = lat_fix;
        exp_pc = 16'h0000;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_req"}, imem_req, 0);
        check_eq({pfx, "_addr"}, imem_addr, 16'h0000);
        check_eq({pfx, "_instr"}, instr, 16'h0000);
        check_eq({pfx, "_op"}, opCode, 0);
        check_eq({pfx, "_fun"}, funCode, 0);
        check_eq({pfx, "_pc"}, pc_out, 16'h0000);
        check_eq({pfx, "_valid"}, id_valid, 0);
        check_eq({pfx, "_halted"}, halted, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        halt_en = 1'b0; lat_rand = 1'b0; lat_fix = 0; model_on = 1'b1;
        mem_wait = 0; ack_cnt = 0; consumed = 0; exp_pc = 16'h0000;

        // reset values
        do_reset();
        check_reset_vals("rst");

        // zero-wait fetch of 0x0123, 0x1456
        cyc();
        check_eq("t1_req0", imem_req, 1);
        check_eq("t1_addr0", imem_addr, 16'h0000);
        check_eq("t1_valid0", id_valid, 0);
        cyc();
        check_eq("t1_addr1", imem_addr, 16'h0002);
        check_eq("t1_valid1", id_valid, 1);
        check_eq("t1_op1", opCode, 4'h0);
        check_eq("t1_fun1", funCode, 4'h3);
        check_eq("t1_pc1", pc_out, 16'h0000);
        cyc();
        check_eq("t1_valid2", id_valid, 1);
        check_eq("t1_op2", opCode, 4'h1);
        check_eq("t1_fun2", funCode, 4'h6);
        check_eq("t1_pc2", pc_out, 16'h0002);

        // stall for 4 cycles with IF/ID live
        stall = 1'b1; ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("t2_hold_instr", instr, 16'h1456);
        end
        check_eq("t2_acks", ack_cnt, QD);
        check_eq("t2_req_off", imem_req, 0);
        stall = 1'b0; c0 = consumed;
        for (int i = 0; i < 6; i++) cyc();
        check_eq("t2_release_cnt", consumed - c0, 6);

        // redirect while the request to 0x0008 waits 3 cycles
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req === 1'b1 && imem_addr == 16'h0008) found = 1'b1;
            else cyc();
        end
        check_eq("t3_reach8", found, 1);
        mem_wait = 3; redirect = 1'b1; redirect_pc = 16'h0040;
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            check_eq("t3_drain_addr", imem_addr, 16'h0008);
            check_eq("t3_drain_req", imem_req, 1);
            check_eq("t3_drain_valid", id_valid, 0);
        end
        cyc();
        check_eq("t3_new_addr", imem_addr, 16'h0040);
        check_eq("t3_new_req", imem_req, 1);
        check_eq("t3_new_valid", id_valid, 0);
        cyc();
        check_eq("t3_first_pc", pc_out, 16'h0040);
        check_eq("t3_first_valid", id_valid, 1);

        // redirect colliding with an ack while stalled (odd target)
        do_reset();
        cyc(); cyc(); cyc();
        check_eq("t4_pre_req", imem_req, 1);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0021;
        cyc();
        stall = 1'b0; redirect = 1'b0;
        check_eq("t4_flush", id_valid, 0);
        check_eq("t4_addr", imem_addr, 16'h0020);
        check_eq("t4_req", imem_req, 1);
        cyc();
        check_eq("t4_pc", pc_out, 16'h0020);
        check_eq("t4_valid", id_valid, 1);

        // Halt at address 6
        halt_en = 1'b1; model_on = 1'b0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (halted === 1'b1) found = 1'b1;
        end
        check_eq("t5_halted", found, 1);
        check_eq("t5_pc", pc_out, 16'h0006);
        check_eq("t5_op", opCode, 4'hF);
        check_eq("t5_req", imem_req, 0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check_eq("t5_stay_halted", halted, 1);
            check_eq("t5_stay_req", imem_req, 0);
        end
        redirect = 1'b1; redirect_pc = 16'h0010;
        cyc();
        redirect = 1'b0; halt_en = 1'b0;
        check_eq("t5_unhalt", halted, 0);
        check_eq("t5_resume_valid", id_valid, 0);
        check_eq("t5_resume_req", imem_req, 1);
        check_eq("t5_resume_addr", imem_addr, 16'h0010);
        model_on = 1'b1; exp_pc = 16'h0010; c0 = consumed;
        for (int i = 0; i < 6; i++) cyc();
        check_eq("t5_resume_cnt", consumed - c0, 5);

        // PC wrap at 0xFFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        cyc();
        redirect = 1'b0;
        check_eq("t6_addr_fffe", imem_addr, 16'hFFFE);
        cyc();
        check_eq("t6_addr_wrap", imem_addr, 16'h0000);
        check_eq("t6_pc_fffe", pc_out, 16'hFFFE);
        cyc(); cyc();

        // reset in the middle of a pending request
        mem_wait = 5;
        cyc();
        check_eq("t7_pending", imem_req, 1);
        rst = 1'b1;
        cyc();
        check_reset_vals("t7");
        rst = 1'b0; mem_wait = lat_fix; exp_pc = 16'h0000;
        cyc();
        check_eq("t7_restart_req", imem_req, 1);
        check_eq("t7_restart_addr", imem_addr, 16'h0000);

        // randomized traffic against the stream model
        lat_rand = 1'b1;
        do_reset();
        c0 = consumed;
        for (int i = 0; i < 1500; i++) begin
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = 16'($urandom_range(0, 16'h01FF));
            cyc();
        end
        stall = 1'b0; redirect = 1'b0;
        check_eq("rnd_progress", ((consumed - c0) > 150) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the pipeline datapath: produces the `opCode`/`funCode` pair and the full instruction word that the decode-stage control unit consumes. It owns the PC, issues requests to instruction memory over a req/ack handshake, buffers returned words, and holds the IF/ID register under decode-stage stall. It flushes on branch/jump redirect and stops fetching at a Halt (`4'b1111`).

## Interface
- `RESET_PC`, default `16'h0000`: PC loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; held high with `imem_addr` stable until `imem_ack`.
- `imem_addr`  out  16  byte address of the requested word.
- `imem_ack`  in  1  `imem_rdata` is valid this cycle; completes the request. Ignored when `imem_req`=0.
- `imem_rdata`  in  16  instruction word.
- `stall`  in  1  decode stage holds IF/ID this cycle.
- `redirect`  in  1  taken branch/jump; flush and refetch from `redirect_pc`.
- `redirect_pc`  in  16  redirect target. Bit 0 is ignored and treated as 0.
- `instr`  out  16  IF/ID instruction word.
- `opCode`  out  4  `instr[15:12]`.
- `funCode`  out  4  `instr[3:0]`.
- `pc_out`  out  16  address of `instr`.
- `id_valid`  out  1  IF/ID holds a live instruction.
- `halted`  out  1  Halt reached IF/ID; fetch stopped.

## Operation
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`/`opCode`/`funCode`/`pc_out`=0, `id_valid`=0, `halted`=0. Queue empty. State FETCH. Reset mid-request abandons the request without waiting for the ack.
- Fetch queue: depth Q (see Configuration). IF/ID loads from the queue head, or directly from `imem_rdata` when the queue is empty (bypass). IF/ID is free when `id_valid`=0, or when `stall`=0.
- States:
  - FETCH: a request is raised when the queue has room, counting the outstanding request. On ack, the word is enqueued or bypassed and `pc` advances by 2, wrapping at 16'hFFFE to 0.
  - DRAIN: entered on `redirect` while a request is unacked. `imem_req` and `imem_addr` stay held; the returning word is discarded. Next state is FETCH at `redirect_pc`.
  - HALT: entered when a word with `opCode`=`4'b1111` loads into IF/ID. Any outstanding request is drained and discarded. The queue is flushed. `imem_req`=0 and `halted`=1. HALT is left only on `rst`, or on `redirect`, which clears `halted` and fetches from `redirect_pc`.
- `redirect` has highest priority:
  - `id_valid` is cleared and the queue is flushed.
  - `pc` is set to `redirect_pc`.
  - A same-cycle ack is discarded.
  - `redirect` overrides `stall`.
- With `stall`=1 and `id_valid`=1, IF/ID outputs hold their values. Returning acks enqueue; they are never dropped, because requests are only issued when the queue has room.

## Timing
- Same-cycle ack is legal: req and ack in the same cycle complete the transfer.
- Bypass latency: ack in cycle N with the queue empty and IF/ID free gives `id_valid`=1 with that word in cycle N+1.
- From a queued word: IF/ID loads on the first edge at which IF/ID is free.
- After `rst` is released, `imem_req`=1 in the first cycle with `imem_addr`=`RESET_PC`.
- Redirect in cycle N: `id_valid`=0 in N+1. If no request is outstanding, `imem_req`=1 with `imem_addr`=`redirect_pc` in N+1. If DRAIN is entered, the request for `redirect_pc` starts the cycle after the drained ack.
- Throughput with zero-wait memory, no stall and `IFU_PREFETCH_EN` defined: one instruction per cycle.
- Throughput without `IFU_PREFETCH_EN`: one instruction per cycle, via bypass.

## Configuration
- `IFU_PREFETCH_EN` defined:
  - Q=2.
  - Fetching continues during `stall` until 2 words are buffered.
- `IFU_PREFETCH_EN` undefined:
  - Q=1.
  - A new request is issued only when the queue is empty and no request is outstanding.
  - Fetch effectively pauses one word ahead of IF/ID during stall.

## Test plan
- Reset then a 0-wait memory returning `16'h0123`, `16'h1456`: `imem_addr` sequence is 0, 2. `opCode`=0 and `funCode`=3 at `pc_out`=0, then `opCode`=1 and `funCode`=6 at `pc_out`=2, on consecutive cycles.
- `stall` held 4 cycles while `id_valid`=1:
  - IF/ID is unchanged throughout.
  - With `IFU_PREFETCH_EN`: exactly 2 further acks accepted, then `imem_req`=0.
  - Without it: exactly 1.
  - Release gives words in address order with none lost.
- `redirect`=1 with `redirect_pc`=`16'h0040` while a request to `16'h0008` waits 3 cycles for ack: the ack data is discarded, then `imem_addr`=`16'h0040`, `id_valid`=0 meanwhile.
- Redirect and ack in the same cycle, with `stall`=1: IF/ID is flushed, the acked word never appears, and the next `pc_out` is `redirect_pc`.
- Halt word `16'hF000` at address 6: `halted`=1 and `imem_req`=0 stay put for 10 cycles. A later `redirect` to `16'h0010` clears `halted` and resumes fetch.
- PC at `16'hFFFE` with normal fetch: the next `imem_addr`=`16'h0000`. `rst` pulsed mid-request: all outputs return to reset values on the next edge.
